stopwatch_sequencer: RTL and testbench

Control FSM that sequences the 4-digit BCD stopwatch datapath (cascaded synchro counters plus lap register plus display mux).
- Turns debounced start/stop, lap and clear button levels into the counter run/clear enables, a lap-capture strobe and the lap-display select.
- Handles lap-display auto-release and stop-at-99.99 saturation.
- Sits between the button debouncers and the counter chain, in the stopwatch top level.

---
 rtl/stopwatch_sequencer.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_sequencer.sv
// -----------------------------------------------------------------------------
// stopwatch_sequencer
//
// Control FSM for the 4-digit BCD stopwatch. It converts the debounced button
// levels into counter run/clear enables, a lap-capture strobe and the display
// select. It also releases the lap display after a programmable hold time and
// stops the count at 99.99.
//
// Parameters
//   LAP_HOLD_TICKS : 100 Hz ticks the lap value stays displayed (0 = forever)
//   HOLD_W         : hold counter width, 2**HOLD_W > LAP_HOLD_TICKS
//   STOP_AT_MAX    : 1 = saturate at 99.99 (FULL state), 0 = counters wrap
//
// Ports
//   qzt_clk_i        : master clock (50 MHz)
//   reset_i          : synchronous, active-high reset
//   tick_i           : 100 Hz enable, one clock wide
//   btn_start_stop_i : debounced start/stop level
//   btn_lap_i        : debounced lap level
//   btn_clear_i      : debounced clear level
//   at_max_i         : datapath shows 99.99
//   run_o            : counter enable
//   clear_o          : one-cycle counter reset strobe
//   capture_o        : one-cycle lap register load strobe
//   show_lap_o       : display select, 1 = lap register, 0 = live count
//   state_o          : current state encoding
// -----------------------------------------------------------------------------
module stopwatch_sequencer #(
    parameter int unsigned LAP_HOLD_TICKS = 300,
    parameter int unsigned HOLD_W         = 9,
    parameter bit          STOP_AT_MAX    = 1'b1
) (
    input  logic       qzt_clk_i,
    input  logic       reset_i,
    input  logic       tick_i,
    input  logic       btn_start_stop_i,
    input  logic       btn_lap_i,
    input  logic       btn_clear_i,
    input  logic       at_max_i,
    output logic       run_o,
    output logic       clear_o,
    output logic       capture_o,
    output logic       show_lap_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        PAUSE     = 3'd2,
        LAP_RUN   = 3'd3,
        LAP_PAUSE = 3'd4,
        FULL      = 3'd5
    } state_e;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LAP_HOLD_TICKS - 1);
    localparam bit                HOLD_EN   = (LAP_HOLD_TICKS > 0);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              run_q, clear_q, capture_q, show_lap_q;
    logic              clear_d, capture_d;
    logic              prev_ss_q, prev_lap_q, prev_clr_q;

    // Rising edges of the button levels; one event per press.
    logic ss_ev, lap_ev, clr_ev, max_hit;

    assign ss_ev   = btn_start_stop_i & ~prev_ss_q;
    assign lap_ev  = btn_lap_i        & ~prev_lap_q;
    assign clr_ev  = btn_clear_i      & ~prev_clr_q;
    assign max_hit = STOP_AT_MAX & at_max_i;

    // Next-state logic. Priority: clear > at_max > start_stop > lap > timeout;
    // only the winning event is acted on.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d   = state_q;
        hold_d    = hold_q;
        clear_d   = 1'b0;
        capture_d = 1'b0;

        if (clr_ev) begin
            state_d = IDLE;
            clear_d = 1'b1;
        end else if (max_hit && (state_q == RUN || state_q == LAP_RUN)) begin
            state_d = FULL;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ss_ev) state_d = RUN;
                end
                RUN: begin
                    if (ss_ev) begin
                        state_d = PAUSE;
                    end else if (lap_ev) begin
                        state_d   = LAP_RUN;
                        capture_d = 1'b1;
                        hold_d    = '0;
                    end
                end
                PAUSE: begin
                    // Resuming with the display already at 99.99 would count
                    // past the limit, so go straight to FULL.
                    if (ss_ev) state_d = max_hit ? FULL : RUN;
                end
                LAP_RUN: begin
                    if (ss_ev) begin
                        state_d = LAP_PAUSE;
                    end else if (lap_ev) begin
                        // Split: recapture and restart the hold window.
                        capture_d = 1'b1;
                        hold_d    = '0;
                    end else if (tick_i) begin
                        if (HOLD_EN && hold_q == HOLD_LAST) begin
                            state_d = RUN;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                LAP_PAUSE: begin
                    if (ss_ev)       state_d = LAP_RUN;
                    else if (lap_ev) state_d = PAUSE;
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // The hold count only survives in the two lap states.
        if (state_d != LAP_RUN && state_d != LAP_PAUSE) hold_d = '0;
    end

    // Single registered FSM: state, hold counter, edge history and outputs.
    always_ff @(posedge qzt_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset_i) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            run_q      <= 1'b0;
            clear_q    <= 1'b0;
            capture_q  <= 1'b0;
            show_lap_q <= 1'b0;
            // History reset high so a button held through reset is no press.
            prev_ss_q  <= 1'b1;
            prev_lap_q <= 1'b1;
            prev_clr_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            clear_q    <= clear_d;
            capture_q  <= capture_d;
            run_q      <= (state_d == RUN)     || (state_d == LAP_RUN);
            show_lap_q <= (state_d == LAP_RUN) || (state_d == LAP_PAUSE);
            prev_ss_q  <= btn_start_stop_i;
            prev_lap_q <= btn_lap_i;
            prev_clr_q <= btn_clear_i;
        end
    end

    assign run_o      = run_q;
    assign clear_o    = clear_q;
    assign capture_o  = capture_q;
    assign show_lap_o = show_lap_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_sequencer
//
// Directed bench for stopwatch_sequencer with LAP_HOLD_TICKS = 3. Inputs are
// driven 1 ns after a rising edge; outputs are checked 1 ns after the edge
// that registers them.
// -----------------------------------------------------------------------------
module tb_stopwatch_sequencer;

    logic       clk = 1'b0;
    logic       reset, tick, btn_ss, btn_lap, btn_clr, at_max;
    logic       run, clear, capture, show_lap;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_sequencer #(
        .LAP_HOLD_TICKS(3),
        .HOLD_W        (2),
        .STOP_AT_MAX   (1'b1)
    ) dut (
        .qzt_clk_i       (clk),
        .reset_i         (reset),
        .tick_i          (tick),
        .btn_start_stop_i(btn_ss),
        .btn_lap_i       (btn_lap),
        .btn_clear_i     (btn_clr),
        .at_max_i        (at_max),
        .run_o           (run),
        .clear_o         (clear),
        .capture_o       (capture),
        .show_lap_o      (show_lap),
        .state_o         (state)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Check the full output set in one call.
    task automatic expect_out(input string tag, input logic [2:0] st, input logic r,
                              input logic c, input logic cap, input logic sl);
        check({tag, ".state"},    32'(state),    32'(st));
        check({tag, ".run"},      32'(run),      32'(r));
        check({tag, ".clear"},    32'(clear),    32'(c));
        check({tag, ".capture"},  32'(capture),  32'(cap));
        check({tag, ".show_lap"}, 32'(show_lap), 32'(sl));
    endtask

    // One-cycle press of the start/stop button followed by release.
    task automatic press_ss(input string tag, input logic [2:0] st, input logic r, input logic sl);
        btn_ss = 1'b1;
        step(1);
        expect_out(tag, st, r, 1'b0, 1'b0, sl);
        btn_ss = 1'b0;
        step(1);
    endtask

    task automatic press_lap(input string tag, input logic [2:0] st, input logic r,
                             input logic cap, input logic sl);
        btn_lap = 1'b1;
        step(1);
        expect_out(tag, st, r, 1'b0, cap, sl);
        btn_lap = 1'b0;
        step(1);
        check({tag, ".cap_off"}, 32'(capture), 32'd0);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0;
        btn_clr = 1'b0; at_max = 1'b0;
        step(3);
        expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(5);
        expect_out("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start, holding the button several cycles: exactly one event.
        btn_ss = 1'b1;
        step(1);
        expect_out("start", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3);
        check("start_held.state", 32'(state), 32'd1);
        btn_ss = 1'b0;
        step(1);
        press_ss("pause", 3'd2, 1'b0, 1'b0);
        press_ss("resume", 3'd1, 1'b1, 1'b0);

        // Lap, then auto-release after three ticks.
        press_lap("lap", 3'd3, 1'b1, 1'b1, 1'b1);
        pulse_tick();
        pulse_tick();
        check("hold2.state", 32'(state), 32'd3);
        check("hold2.show_lap", 32'(show_lap), 32'd1);
        pulse_tick();
        expect_out("release", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Lap, split, then pause the lap display: no release while paused.
        press_lap("lap2", 3'd3, 1'b1, 1'b1, 1'b1);
        pulse_tick();
        press_lap("split", 3'd3, 1'b1, 1'b1, 1'b1);
        pulse_tick();
        pulse_tick();
        check("split_hold.state", 32'(state), 32'd3);
        press_ss("lap_pause", 3'd4, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) pulse_tick();
        expect_out("lap_pause_ticks", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        press_lap("lap_release", 3'd2, 1'b0, 1'b0, 1'b0);

        // Clear beats start_stop and lap in the same cycle.
        press_ss("resume2", 3'd1, 1'b1, 1'b0);
        btn_clr = 1'b1; btn_ss = 1'b1; btn_lap = 1'b1;
        step(1);
        expect_out("clr_prio", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        btn_clr = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0;
        step(1);
        check("clr_one_cycle", 32'(clear), 32'd0);

        // Saturation at 99.99 from RUN.
        press_ss("run3", 3'd1, 1'b1, 1'b0);
        at_max = 1'b1;
        step(1);
        expect_out("full", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        press_ss("full_ss", 3'd5, 1'b0, 1'b0);
        press_lap("full_lap", 3'd5, 1'b0, 1'b0, 1'b0);
        btn_clr = 1'b1;
        step(1);
        expect_out("full_clr", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        btn_clr = 1'b0; at_max = 1'b0;
        step(1);

        // Saturation from LAP_RUN drops the lap display.
        press_ss("run4", 3'd1, 1'b1, 1'b0);
        press_lap("lap4", 3'd3, 1'b1, 1'b1, 1'b1);
        at_max = 1'b1;
        step(1);
        expect_out("lap_full", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        at_max = 1'b0;
        btn_clr = 1'b1;
        step(1);
        btn_clr = 1'b0;
        step(1);

        // Resume from PAUSE with at_max high goes to FULL.
        press_ss("run5", 3'd1, 1'b1, 1'b0);
        press_ss("pause5", 3'd2, 1'b0, 1'b0);
        at_max = 1'b1;
        step(1);
        check("pause_max.state", 32'(state), 32'd2);
        press_ss("pause_full", 3'd5, 1'b0, 1'b0);
        at_max = 1'b0;
        btn_clr = 1'b1;
        step(1);
        btn_clr = 1'b0;
        step(1);
        check("cleared.state", 32'(state), 32'd0);

        // Button held through reset release produces no event.
        btn_ss = 1'b1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(3);
        check("held_reset.state", 32'(state), 32'd0);
        btn_ss = 1'b0;
        step(1);
        check("held_release.state", 32'(state), 32'd0);
        press_ss("after_reset", 3'd1, 1'b1, 1'b0);

        // Reset in LAP_RUN with an event pending.
        press_lap("lap6", 3'd3, 1'b1, 1'b1, 1'b1);
        reset = 1'b1; btn_ss = 1'b1;
        step(1);
        expect_out("mid_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; btn_ss = 1'b0;
        step(2);
        check("post_reset.state", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
